// File: rtl/md_pkg.sv
// Shared types and op-class helpers for the multiply/divide issue logic.
package md_pkg;

  localparam int CNT_W = 8;

  typedef enum logic [3:0] {
    NONE  = 4'd0,
    MULT  = 4'd1,
    MULTU = 4'd2,
    DIV   = 4'd3,
    DIVU  = 4'd4,
    MADD  = 4'd5,
    MADDU = 4'd6,
    MSUB  = 4'd7,
    MSUBU = 4'd8,
    MTHI  = 4'd9,
    MTLO  = 4'd10,
    MFHI  = 4'd11,
    MFLO  = 4'd12
  } md_op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } md_state_t;

  function automatic logic is_compute(md_op_t op);
    return op inside {MULT, MULTU, DIV, DIVU, MADD, MADDU, MSUB, MSUBU};
  endfunction

  function automatic logic is_move_to(md_op_t op);
    return op inside {MTHI, MTLO};
  endfunction

  function automatic logic is_move_from(md_op_t op);
    return op inside {MFHI, MFLO};
  endfunction

endpackage

// File: rtl/md_latency_ctr.sv
// Expected-latency down-counter and WAIT timeout up-counter for md_issue.
module md_latency_ctr
  import md_pkg::*;
#(
  parameter int TIMEOUT = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] lat_init,
  input  logic             run,
  input  logic             clear,
  output logic             lat_zero,
  output logic             timed_out
);

  logic [CNT_W-1:0] lat_cnt;
  logic [CNT_W-1:0] to_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lat_cnt <= '0;
      to_cnt  <= '0;
    end else if (load) begin
      lat_cnt <= lat_init;
      to_cnt  <= '0;
    end else if (clear) begin
      lat_cnt <= '0;
      to_cnt  <= '0;
    end else if (run) begin
      if (lat_cnt != '0) lat_cnt <= lat_cnt - 1'b1;
      to_cnt <= to_cnt + 1'b1;
    end
  end

  // The count expires at the end of the cycle holding 1, so a response in the
  // last expected WAIT cycle is on time.
  assign lat_zero  = (lat_cnt <= CNT_W'(1));
  assign timed_out = run && (to_cnt == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/md_issue.sv
// E-stage initiator for the multiply/divide unit: request capture, handshake,
// D-stage stall generation and sticky protocol-error detection.
module md_issue
  import md_pkg::*;
#(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10,
  parameter int TIMEOUT  = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  md_op_t      d_op,
  input  logic        e_valid,
  input  md_op_t      e_op,
  input  logic [31:0] e_rs,
  input  logic [31:0] e_rt,
  output logic        req_valid,
  output md_op_t      req_op,
  output logic [31:0] req_a,
  output logic [31:0] req_b,
  input  logic        req_ready,
  input  logic        rsp_valid,
  output logic        stall_d,
  output logic        busy,
  output logic        err
);

  md_state_t        state;
  logic             e_issue;
  logic             d_md;
  logic             lat_load;
  logic             lat_clear;
  logic             in_wait;
  logic             lat_zero;
  logic             timed_out;
  logic             err_set;
  logic [CNT_W-1:0] lat_init;

  assign e_issue = e_valid && (is_compute(e_op) || is_move_to(e_op));
  assign d_md    = is_compute(d_op) || is_move_to(d_op) || is_move_from(d_op);
  assign stall_d = d_md && (busy || e_issue);

  assign in_wait   = (state == S_WAIT);
  assign lat_load  = (state == S_REQ) && req_ready && is_compute(req_op);
  assign lat_clear = in_wait && (rsp_valid || timed_out);
  assign lat_init  = (req_op == DIV || req_op == DIVU) ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);

  assign err_set = (rsp_valid && !in_wait)
                || (rsp_valid && in_wait && !lat_zero)
                || (e_issue && busy)
                || timed_out;

  md_latency_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_ctr (
    .clk       (clk),
    .reset     (reset),
    .load      (lat_load),
    .lat_init  (lat_init),
    .run       (in_wait),
    .clear     (lat_clear),
    .lat_zero  (lat_zero),
    .timed_out (timed_out)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      req_valid <= 1'b0;
      req_op    <= NONE;
      req_a     <= '0;
      req_b     <= '0;
      busy      <= 1'b0;
      err       <= 1'b0;
    end else begin
      if (err_set) err <= 1'b1;
      case (state)
        S_IDLE: begin
          // A coincident stray response wins; the op is dropped.
          if (e_issue && !rsp_valid) begin
            req_op    <= e_op;
            req_a     <= e_rs;
            req_b     <= e_rt;
            req_valid <= 1'b1;
            busy      <= 1'b1;
            state     <= S_REQ;
          end
        end
        S_REQ: begin
          if (req_ready) begin
            req_valid <= 1'b0;
            if (is_compute(req_op)) begin
              state <= S_WAIT;
            end else begin
              busy  <= 1'b0;
              state <= S_IDLE;
            end
          end
        end
        S_WAIT: begin
          if (rsp_valid || timed_out) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: begin
          req_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_md_issue.sv
// Directed bench for md_issue with default latencies (5/10) and timeout 32.
module tb_md_issue;
  import md_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  md_op_t      d_op;
  logic        e_valid;
  md_op_t      e_op;
  logic [31:0] e_rs;
  logic [31:0] e_rt;
  logic        req_valid;
  md_op_t      req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        req_ready;
  logic        rsp_valid;
  logic        stall_d;
  logic        busy;
  logic        err;

  int checks = 0;
  int errors = 0;

  md_issue dut (
    .clk       (clk),
    .reset     (reset),
    .d_op      (d_op),
    .e_valid   (e_valid),
    .e_op      (e_op),
    .e_rs      (e_rs),
    .e_rt      (e_rt),
    .req_valid (req_valid),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .stall_d   (stall_d),
    .busy      (busy),
    .err       (err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    tick();
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0; d_op = NONE; e_valid = 1'b0; e_op = NONE;
    e_rs = '0; e_rt = '0; req_ready = 1'b0; rsp_valid = 1'b0;

    // Reset state
    sample();
    chk("rst_busy", busy, 0);
    chk("rst_req_valid", req_valid, 0);
    chk("rst_req_op", req_op, NONE);
    chk("rst_req_a", req_a, 0);
    chk("rst_req_b", req_b, 0);
    chk("rst_err", err, 0);
    chk("rst_stall", stall_d, 0);
    tick();
    reset = 1'b1;
    tick();

    // MULT 7*6, ready high, response in the 5th WAIT cycle; MFLO in D
    e_valid = 1'b1; e_op = MULT; e_rs = 32'd7; e_rt = 32'd6;
    d_op = MFLO; req_ready = 1'b1;
    sample();
    chk("mult_e_stall", stall_d, 1);
    chk("mult_e_busy", busy, 0);
    tick();
    e_valid = 1'b0; e_op = NONE;
    sample();
    chk("mult_req_valid", req_valid, 1);
    chk("mult_req_op", req_op, MULT);
    chk("mult_req_a", req_a, 7);
    chk("mult_req_b", req_b, 6);
    chk("mult_req_stall", stall_d, 1);
    tick();
    for (int i = 0; i < 5; i++) begin
      rsp_valid = (i == 4);
      sample();
      chk("mult_wait_stall", stall_d, 1);
      chk("mult_wait_busy", busy, 1);
      chk("mult_wait_rv", req_valid, 0);
      tick();
    end
    rsp_valid = 1'b0;
    sample();
    chk("mult_done_stall", stall_d, 0);
    chk("mult_done_busy", busy, 0);
    chk("mult_done_err", err, 0);
    tick();
    d_op = NONE;

    // DIVU with ready low for 3 REQ cycles; D op NONE never stalls
    e_valid = 1'b1; e_op = DIVU; e_rs = 32'd100; e_rt = 32'd7; req_ready = 1'b0;
    sample();
    chk("divu_e_stall_none", stall_d, 0);
    tick();
    e_valid = 1'b0; e_op = NONE;
    for (int i = 0; i < 4; i++) begin
      req_ready = (i == 3);
      sample();
      chk("divu_req_valid", req_valid, 1);
      chk("divu_req_op", req_op, DIVU);
      chk("divu_req_a", req_a, 100);
      chk("divu_req_b", req_b, 7);
      chk("divu_req_stall_none", stall_d, 0);
      tick();
    end
    for (int i = 0; i < 10; i++) begin
      rsp_valid = (i == 9);
      sample();
      chk("divu_wait_busy", busy, 1);
      chk("divu_wait_rv", req_valid, 0);
      tick();
    end
    rsp_valid = 1'b0;
    sample();
    chk("divu_done_busy", busy, 0);
    chk("divu_done_err", err, 0);
    tick();

    // MTHI: single REQ cycle, no response; MFHI in D stalls exactly 2 cycles
    e_valid = 1'b1; e_op = MTHI; e_rs = 32'hDEADBEEF; e_rt = 32'h0; d_op = MFHI; req_ready = 1'b1;
    sample();
    chk("mthi_stall0", stall_d, 1);
    tick();
    e_valid = 1'b0; e_op = NONE;
    sample();
    chk("mthi_stall1", stall_d, 1);
    chk("mthi_req_valid", req_valid, 1);
    chk("mthi_req_a", req_a, 32'hDEADBEEF);
    chk("mthi_req_op", req_op, MTHI);
    tick();
    sample();
    chk("mthi_stall2", stall_d, 0);
    chk("mthi_idle_busy", busy, 0);
    chk("mthi_idle_rv", req_valid, 0);
    chk("mthi_err", err, 0);
    tick();
    d_op = NONE;

    // MULT with response while the latency count is 3: early, sticky error
    e_valid = 1'b1; e_op = MULT; e_rs = 32'd3; e_rt = 32'd4;
    tick();
    e_valid = 1'b0; e_op = NONE;
    tick();
    tick();
    tick();
    rsp_valid = 1'b1;
    sample();
    chk("early_pre_err", err, 0);
    chk("early_busy", busy, 1);
    tick();
    rsp_valid = 1'b0;
    sample();
    chk("early_err", err, 1);
    chk("early_idle", busy, 0);
    tick();
    e_valid = 1'b1; e_op = MTLO; e_rs = 32'd1;
    tick();
    e_valid = 1'b0; e_op = NONE;
    tick();
    sample();
    chk("early_err_sticky", err, 1);
    chk("early_mtlo_idle", busy, 0);
    tick();
    do_reset();
    sample();
    chk("reset_clears_err", err, 0);
    tick();

    // DIV with no response: timeout after 32 WAIT cycles
    e_valid = 1'b1; e_op = DIV; e_rs = 32'd9; e_rt = 32'd3;
    tick();
    e_valid = 1'b0; e_op = NONE;
    tick();
    for (int i = 0; i < 32; i++) begin
      sample();
      chk("to_wait_busy", busy, 1);
      chk("to_wait_err", err, 0);
      tick();
    end
    sample();
    chk("to_err", err, 1);
    chk("to_idle", busy, 0);
    tick();
    do_reset();

    // Reset mid-WAIT, then a stray response
    e_valid = 1'b1; e_op = MULT; e_rs = 32'd2; e_rt = 32'd2;
    tick();
    e_valid = 1'b0; e_op = NONE;
    tick();
    tick();
    sample();
    chk("mid_busy_before", busy, 1);
    reset = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_rv", req_valid, 0);
    chk("mid_rst_err", err, 0);
    tick();
    reset = 1'b1;
    tick();
    rsp_valid = 1'b1;
    tick();
    rsp_valid = 1'b0;
    sample();
    chk("stray_rsp_err", err, 1);
    chk("stray_rsp_busy", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/md_issue.md
# md_issue

Initiator side of the multiply/divide unit handshake. Sits at the E-stage boundary of the five-stage pipeline:
- captures E-stage multiply/divide-class operations and their operands into a request register;
- presents each request to the multiply/divide unit with a valid/ready handshake and tracks the response;
- drives the D-stage stall for every HI/LO-touching instruction while an operation is outstanding;
- flags protocol violations in a sticky error bit.

## Interface
Parameters:
- `MULT_LAT`, default 5: expected cycles from request accept to response for MULT/MULTU/MADD/MADDU/MSUB/MSUBU.
- `DIV_LAT`, default 10: expected cycles from request accept to response for DIV/DIVU.
- `TIMEOUT`, default 32: number of WAIT cycles after which the error bit sets if no response has arrived.

Ports:
- `clk`, in, 1: the single clock.
- `reset`, in, 1: asynchronous, active-low reset.
- `d_op`, in, 4: operation class of the D-stage instruction (`md_op_t`).
- `e_valid`, in, 1: E-stage holds a real instruction.
- `e_op`, in, 4: operation class of the E-stage instruction.
- `e_rs`, `e_rt`, in, 32 each: forwarded E-stage operands.
- `req_valid`, out, 1: request pending to the multiply/divide unit.
- `req_op`, out, 4: requested operation.
- `req_a`, `req_b`, out, 32 each: request operands.
- `req_ready`, in, 1: the multiply/divide unit accepts the request this cycle.
- `rsp_valid`, in, 1: one-cycle pulse; HI/LO have been updated.
- `stall_d`, out, 1: freeze PC, F and D stages, and insert a bubble into E.
- `busy`, out, 1: state is not IDLE.
- `err`, out, 1: sticky protocol error.

## Operation
Operation classes:
- "compute": MULT, MULTU, DIV, DIVU, MADD, MADDU, MSUB, MSUBU.
- "move-to": MTHI, MTLO.
- "move-from": MFHI, MFLO.
- "md-class": the union of all three.

The state machine is IDLE, REQ, WAIT.
- IDLE:
  - `e_valid` with a compute or move-to op: at the clock edge, capture `e_op`, `e_rs`, `e_rt` into `req_op`/`req_a`/`req_b` and go to REQ.
  - move-from ops and NONE are ignored.
- REQ: `req_valid`=1 and the request registers are held stable.
  - `req_ready`=1 with a compute op: load the latency counter with `MULT_LAT` or `DIV_LAT` and go to WAIT.
  - `req_ready`=1 with a move-to op: go directly to IDLE; no response is expected.
- WAIT:
  - The latency counter decrements, saturating at 0.
  - A separate timeout counter increments each cycle.
  - `rsp_valid`=1: go to IDLE and clear both counters.
  - Timeout counter reaches `TIMEOUT`: set `err`, go to IDLE.

Stall rule:
- `stall_d` = (`d_op` is md-class) AND (`busy` OR (`e_valid` AND `e_op` is compute or move-to)).
- `stall_d` = 0 when `d_op` is NONE.

`err` sets, and stays set until reset, on any of:
- `rsp_valid` in IDLE or REQ;
- `rsp_valid` in WAIT while the latency counter is not 0 (early response);
- `e_valid` with a compute or move-to op while `busy` (the stall rule should make this impossible);
- the WAIT timeout.

## Timing
- Reset (asynchronous, `reset`=0): state IDLE; `req_valid` 0; `req_op` NONE; `req_a`/`req_b` 0; both counters 0; `err` 0; `busy` 0.
- `req_valid` is registered and asserts in the cycle after the E-stage op is captured.
- `stall_d`:
  - combinational;
  - asserts in the same cycle a compute op sits in E;
  - deasserts in the cycle after the `rsp_valid` edge.
- Minimum occupancy, with `req_ready` always 1:
  - MULT: 1 REQ cycle + `MULT_LAT` WAIT cycles.
  - MTHI: 1 REQ cycle.
- `req_ready` held low: REQ persists indefinitely, with no timeout in REQ.
- Reset asserted mid-WAIT: return to IDLE immediately; a later `rsp_valid` sets `err`.
- `rsp_valid` and a new E-stage op in the same cycle cannot both be legal, because the D-stage stall prevents it. If they coincide, set `err`, take the response, and ignore the op.

## Structure
- Shared package `md_pkg`:
  - `md_op_t` enum: NONE=0, MULT, MULTU, DIV, DIVU, MADD, MADDU, MSUB, MSUBU, MTHI, MTLO, MFHI, MFLO;
  - state enum;
  - class helper functions `is_compute`, `is_move_to`, `is_move_from`.
- One sub-module: `md_latency_ctr`, holding the load/decrement latency counter plus the timeout counter, with outputs `lat_zero` and `timed_out`.

## Test plan
- MULT, `e_rs`=7, `e_rt`=6, `req_ready`=1, `rsp_valid` 5 cycles after accept:
  - `req_a`=7, `req_b`=6, `req_op`=MULT;
  - `stall_d` high for a D-stage MFLO until the cycle after the response;
  - `err`=0.
- DIVU with `req_ready` low for 3 cycles, then high, `rsp_valid` after 10 cycles: REQ held 4 cycles with operands stable, then WAIT for 10 cycles, then IDLE, `err`=0.
- MTHI, `e_rs`=0xDEADBEEF: one REQ cycle, back to IDLE with no response; a following MFHI stalls exactly 2 cycles.
- MULT with `rsp_valid` at latency count 3 (early): `err`=1 and stays 1 through later traffic.
- DIV with no response: `err`=1 after 32 WAIT cycles, state IDLE.
- Reset pulled low mid-WAIT, then `rsp_valid`: state IDLE immediately; `err`=1 after the stray response.
